// File: rtl/mul_pkg.sv
// Shared types for the byte-serial multiplier: FSM states, digit width and
// the 3:2 carry-save compressor used by the Wallace stage.
package mul_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} mul_state_e;

  localparam int DIGIT_W = 8;

  typedef struct packed {
    logic [15:0] sum;
    logic [15:0] carry;
  } csa_t;

  // Full-adder row: three addends in, sum and carry rows out, value preserved mod 2^16.
  function automatic csa_t csa3(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/wallacetree8x8.sv
// Combinational 8x8 unsigned multiplier: eight partial-product rows reduced by
// a carry-save tree to two rows, then one carry-propagate add.
module wallacetree8x8
  import mul_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] row [8];
  csa_t l1a, l1b, l2a, l2b, l3, l4;

  // Rows 8 -> 6 -> 4 -> 3 -> 2; the product fits 16 bits, so dropped carries are zero.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      row[k] = {8'b0, a & {8{b[k]}}} << k;
    end
    l1a = csa3(row[0], row[1], row[2]);
    l1b = csa3(row[3], row[4], row[5]);
    l2a = csa3(l1a.sum, l1a.carry, l1b.sum);
    l2b = csa3(l1b.carry, row[6], row[7]);
    l3  = csa3(l2a.sum, l2a.carry, l2b.sum);
    l4  = csa3(l3.sum, l3.carry, l2b.carry);
    p   = l4.sum + l4.carry;
  end

endmodule

// File: rtl/mul32_seq_wallace.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one 8x8 Wallace stage is reused
// for every byte pair and its shifted products are summed in an accumulator.
module mul32_seq_wallace
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int NSTEP = NDIG * NDIG;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  mul_state_e state, next_state;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   i, j;
  logic               last_q;
  logic [7:0]         a_byte, b_byte;
  logic [15:0]        pp;
  logic [CNT_W:0]     shift_dig;
  logic [PW-1:0]      pp_shifted;

  assign a_byte     = a_q[DIGIT_W*i +: DIGIT_W];
  assign b_byte     = b_q[DIGIT_W*j +: DIGIT_W];
  assign shift_dig  = {1'b0, i} + {1'b0, j};
  assign pp_shifted = PW'(pp) << (DIGIT_W * shift_dig);

  wallacetree8x8 u_tree (
    .a (a_byte),
    .b (b_byte),
    .p (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_CALC;
      end
      ST_CALC: begin
        if (last_q) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // After the final byte pair is summed, one extra CALC cycle moves acc into prod.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      i      <= '0;
      j      <= '0;
      last_q <= 1'b0;
      prod   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            acc    <= '0;
            i      <= '0;
            j      <= '0;
            last_q <= 1'b0;
          end
        end
        ST_CALC: begin
          if (last_q) begin
            prod   <= acc;
            last_q <= 1'b0;
          end else begin
            acc <= acc + pp_shifted;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i      <= '0;
                last_q <= 1'b1;
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq_wallace.sv
// Directed and random checks of mul32_seq_wallace against plain 64-bit multiplication.
module tb_mul32_seq_wallace;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul32_seq_wallace #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair and count cycles until out_valid appears.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input bit noisy,
                               output int lat);
    int wait_cyc;
    wait_cyc = 0;
    @(negedge clk);
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    checkOutput("in_ready_before_op", 64'(in_ready), 64'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      if (noisy) begin
        a = $urandom;
        b = $urandom;
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      #1;
      if (noisy && !out_valid) checkOutput("in_ready_calc", 64'(in_ready), 64'd0);
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
  endtask

  task automatic runOp(input logic [31:0] x, input logic [31:0] y, input bit noisy,
                       input int hold, input string tag);
    logic [63:0] exp;
    int lat;
    exp = {32'b0, x} * {32'b0, y};
    applyStimulus(x, y, noisy, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd17);
    checkOutput({tag, "_prod"}, prod, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      checkOutput({tag, "_hold_prod"}, prod, exp);
      checkOutput({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_post_prod"}, prod, exp);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_prod", prod, 64'd0);
    rst = 1'b0;

    runOp(32'd3, 32'd5, 1'b0, 0, "small");
    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "all_ones");
    runOp(32'h0001_0000, 32'h0001_0000, 1'b0, 0, "cross_mid");
    runOp(32'h8000_0000, 32'd2, 1'b0, 0, "cross_top");
    runOp(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "times_one");
    runOp(32'd0, 32'd0, 1'b0, 0, "zeros");
    runOp(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5, "backpressure");
    runOp(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 0, "isolation");

    // Abandon an operation partway through CALC.
    @(negedge clk);
    a = 32'hFFFF_0000;
    b = 32'h0000_FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_prod", prod, 64'd0);
    runOp(32'd7, 32'd9, 1'b0, 0, "after_reset");

    for (int r = 0; r < 8; r++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      runOp(ra, rb, 1'(r % 2), r % 3, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
